// File: rtl/divisor_if.sv
// Operand/result bundle for the shift-subtract divider.
// The master drives operands and init; the slave publishes results.
interface divisor_if #(
  parameter int WIDTH = 3
);
  logic             init;
  logic [WIDTH-1:0] DD;
  logic [WIDTH-1:0] DR;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output init, DD, DR,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  init, DD, DR,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/divisor.sv
// Restoring shift-subtract unsigned divider: one quotient bit per SHIFT/SUB pair.
// Results are published only on completion; divide-by-zero finishes immediately.
module divisor #(
  parameter int WIDTH = 3
) (
  input  logic      clk,
  input  logic      reset,
  divisor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SUB, FIN} state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  // Trial subtraction; R carries one extra bit so the shifted value never overflows.
  logic             sub_ge;
  logic [WIDTH:0]   r_sub;
  logic [WIDTH-1:0] q_sub;

  always_comb begin
    sub_ge = r >= {1'b0, d};
    r_sub  = sub_ge ? (r - {1'b0, d}) : r;
    q_sub  = {q[WIDTH-1:1], sub_ge};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.init) begin
            busy <= 1'b1;
            if (bus.DR != '0) begin
              r           <= '0;
              q           <= bus.DD;
              d           <= bus.DR;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              state       <= SHIFT;
            end else begin
              quotient    <= '1;
              remainder   <= bus.DD;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= FIN;
            end
          end
        end
        SHIFT: begin
          {r, q} <= {r[WIDTH-1:0], q, 1'b0};
          state  <= SUB;
        end
        SUB: begin
          r   <= r_sub;
          q   <= q_sub;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= q_sub;
            remainder <= r_sub[WIDTH-1:0];
            done      <= 1'b1;
            state     <= FIN;
          end else begin
            state <= SHIFT;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.done        = done;
  assign bus.busy        = busy;
  assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_divisor.sv
// Directed bench for the 3-bit divider: vector table, abort/ignore sequences,
// and a back-to-back sweep of every operand pair.
module tb_divisor;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  divisor_if #(.WIDTH(W)) bus ();
  divisor #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dd;
    int dr;
    int q;
    int r;
    int dz;
    int lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Start one op, wait for done, check results, latency, busy, and done width.
  task automatic run_op(input vec_t v);
    int lat;
    int busy_ok;
    string tag;
    tag = $sformatf("%0d/%0d", v.dd, v.dr);
    @(negedge clk);
    bus.DD = W'(v.dd); bus.DR = W'(v.dr); bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    lat = 0;
    busy_ok = 1;
    while (!bus.done && lat < 20) begin
      if (!bus.busy) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    check({tag, " done_seen"}, int'(bus.done), 1);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " busy"}, busy_ok & int'(bus.busy), 1);
    check({tag, " quotient"}, int'(bus.quotient), v.q);
    check({tag, " remainder"}, int'(bus.remainder), v.r);
    check({tag, " div_by_zero"}, int'(bus.div_by_zero), v.dz);
    @(negedge clk);
    check({tag, " done_low_after"}, int'(bus.done), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int w;
    int seen;
    int last;
    vec_t v;

    vecs[0] = '{7, 2, 3, 1, 0, 6};
    vecs[1] = '{2, 5, 0, 2, 0, 6};
    vecs[2] = '{6, 3, 2, 0, 0, 6};
    vecs[3] = '{7, 1, 7, 0, 0, 6};
    vecs[4] = '{5, 0, 7, 5, 1, 0};
    vecs[5] = '{4, 2, 2, 0, 0, 6};
    vecs[6] = '{0, 3, 0, 0, 0, 6};
    vecs[7] = '{3, 3, 1, 0, 0, 6};
    vecs[8] = '{6, 7, 0, 6, 0, 6};

    reset = 1'b0;
    bus.init = 1'b0; bus.DD = '0; bus.DR = '0;
    repeat (3) @(negedge clk);
    check("reset quotient", int'(bus.quotient), 0);
    check("reset remainder", int'(bus.remainder), 0);
    check("reset done", int'(bus.done), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset div_by_zero", int'(bus.div_by_zero), 0);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Operand change and re-init while busy must not disturb 7/3.
    @(negedge clk);
    bus.DD = 3'd7; bus.DR = 3'd3; bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    @(negedge clk);
    bus.DD = 3'd1; bus.DR = 3'd1; bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    w = 0;
    while (!bus.done && w < 20) begin @(negedge clk); w++; end
    check("ignore done_seen", int'(bus.done), 1);
    check("ignore quotient", int'(bus.quotient), 2);
    check("ignore remainder", int'(bus.remainder), 1);
    seen = 0;
    repeat (14) begin @(negedge clk); if (bus.done) seen++; end
    check("ignore no_second_done", seen, 0);

    // Reset mid-operation discards the in-flight 7/2.
    bus.DD = 3'd7; bus.DR = 3'd2; bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort quotient", int'(bus.quotient), 0);
    check("abort remainder", int'(bus.remainder), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (bus.done) seen++; end
    check("abort no_done", seen, 0);
    v = '{6, 4, 1, 2, 0, 6};
    run_op(v);

    // Back-to-back sweep with init held high.
    @(negedge clk);
    bus.DD = '0; bus.DR = '0; bus.init = 1'b1;
    last = 0;
    for (int i = 0; i < 64; i++) begin
      int dd;
      int dr;
      dd = i / 8;
      dr = i % 8;
      w = 0;
      do begin @(negedge clk); w++; end while (!bus.done && w < 20);
      check($sformatf("sweep %0d/%0d done_seen", dd, dr), int'(bus.done), 1);
      check($sformatf("sweep %0d/%0d quotient", dd, dr), int'(bus.quotient), dr == 0 ? 7 : dd / dr);
      check($sformatf("sweep %0d/%0d remainder", dd, dr), int'(bus.remainder), dr == 0 ? dd : dd % dr);
      check($sformatf("sweep %0d/%0d div_by_zero", dd, dr), int'(bus.div_by_zero), dr == 0 ? 1 : 0);
      if (i > 0)
        check($sformatf("sweep %0d/%0d spacing", dd, dr), cyc - last, dr == 0 ? 2 : 8);
      last = cyc;
      if (i < 63) begin
        bus.DD = W'((i + 1) / 8);
        bus.DR = W'((i + 1) % 8);
      end
    end
    bus.init = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
